mul_unit_seq: RTL and testbench
===============================

Name: mul_unit_seq

Overview:
- Parametrised, multi-cycle multiply / multiply-accumulate unit for the ARM core datapath.
- Successor to the single-cycle multiply path. Adds configurable width, configurable radix (bits retired per cycle), 64-bit long forms (signed and unsigned), a start/busy/done handshake, and a synchronous flush.
- Sits beside the ALU. The controller stalls the pipeline while busy=1 and writes result_lo/result_hi back to the register file when done=1.

Parameters:
- WIDTH, 32, operand width in bits; result is 2*WIDTH wide.
- RADIX_BITS, 1, multiplier bits retired per CALC cycle; must divide WIDTH; allowed values 1, 2, 4, 8.

Ports:
- clk  input  1  clock; rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; accepted only in IDLE or DONE.
- flush  input  1  synchronous abort to IDLE; no done pulse.
- mode  input  3  000 MUL, 001 MLA, 100 UMULL, 101 UMLAL, 110 SMULL, 111 SMLAL; other codes behave as MUL.
- src_a  input  WIDTH  multiplicand (Rm).
- src_b  input  WIDTH  multiplier (Rs).
- acc_lo  input  WIDTH  accumulate low word (Rn for MLA, RdLo for long accumulate).
- acc_hi  input  WIDTH  accumulate high word (RdHi); used by long-accumulate modes only.
- busy  output  1  high in CALC.
- done  output  1  one-cycle pulse; result valid.
- result_lo  output  WIDTH  low result word.
- result_hi  output  WIDTH  high result word; 0 for MUL/MLA.
- flag_n  output  1  MSB of result_hi (long modes) or result_lo (short modes).
- flag_z  output  1  1 when every result bit of the mode's width is zero.

Behaviour:
- Reset (asynchronous, at any time, including mid-operation): state=IDLE; counter=0; busy, done, result_lo, result_hi, flag_n and flag_z all 0.
- States: IDLE, CALC, DONE. Encoding is free.
- IDLE/DONE with start=1 and flush=0, at edge E:
  - latch mode, src_a, src_b, acc_lo, acc_hi;
  - initialise the partial product to the accumulator (MLA: {0, acc_lo}; long-accumulate: {acc_hi, acc_lo}; otherwise 0);
  - set counter=0 and go to CALC.
- DONE with start=0: go to IDLE.
- CALC: each edge adds RADIX_BITS of the multiplier into the partial product and increments the counter.
  - Signed modes treat both operands as two's complement; the exact signed 2*WIDTH product is required. Implementation is free (e.g. negative-weight MSB step or sign correction).
  - After N = WIDTH/RADIX_BITS CALC edges (edge E+N), register the results and flags and go to DONE.
- Latency: done=1 in the cycle following edge E+N (N=32 at defaults; N=8 with RADIX_BITS=4). busy=1 during cycles E+1..E+N.
- Outputs hold the last result from DONE through IDLE until the next DONE. They do not change during CALC.
- Short modes (MUL/MLA): result_lo = low WIDTH bits, modulo 2^WIDTH; result_hi = 0.
- Long modes: {result_hi, result_lo} = product + accumulator, modulo 2^(2*WIDTH).
- start while busy is ignored; latched operands are unaffected.
- flush=1 at any edge: state=IDLE, counter=0, no done pulse, result registers unchanged. flush has priority over start.
- Back-to-back operation: start=1 in the DONE cycle begins the next operation; done is low in the following cycle.
- Input ports may change freely after the accept edge.

Test Plan:
- Defaults, MUL src_a=7, src_b=6 -> done exactly 32 edges after accept; result_lo=42, result_hi=0, flag_n=0, flag_z=0; busy high for exactly 32 cycles.
- SMULL src_a=0xFFFFFFFD (-3), src_b=5 -> result_hi=0xFFFFFFFF, result_lo=0xFFFFFFF1, flag_n=1.
- UMLAL src_a=src_b=0xFFFFFFFF, acc_hi=0, acc_lo=1 -> result_hi=0xFFFFFFFE, result_lo=0x00000002.
- MLA src_a=0x80000000, src_b=2, acc_lo=5 -> result_lo=5, result_hi=0. Then MUL src_a=0, src_b=0x1234 -> result_lo=0, flag_z=1.
- Busy-time events:
  - start pulse 10 cycles after accepting MUL 3*4 -> ignored; result still 12.
  - flush at cycle 10 -> no done, IDLE, previous results held.
  - reset asserted mid-CALC between edges -> all outputs 0 immediately.
- RADIX_BITS=4: SMLAL src_a=0xFFFFFFFF, src_b=0xFFFFFFFF, acc={0,0xFFFFFFFF} -> done 8 edges after accept; result={0x00000001, 0x00000000}. Back-to-back start in the DONE cycle is accepted.

Source files
------------

// File: rtl/mul_unit_seq_if.sv
// Handshake, operand and result bundle between the core controller and mul_unit_seq.
interface mul_unit_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             flush;
  logic [2:0]       mode;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] acc_hi;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             flag_n;
  logic             flag_z;

  modport master (
    output start, flush, mode, src_a, src_b, acc_lo, acc_hi,
    input  busy, done, result_lo, result_hi, flag_n, flag_z
  );

  modport slave (
    input  start, flush, mode, src_a, src_b, acc_lo, acc_hi,
    output busy, done, result_lo, result_hi, flag_n, flag_z
  );
endinterface

// File: rtl/mul_unit_seq.sv
// Multi-cycle MUL/MLA/UMULL/UMLAL/SMULL/SMLAL unit retiring RADIX_BITS multiplier bits per cycle.
module mul_unit_seq #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned RADIX_BITS = 1
) (
  input  logic          clk,
  input  logic          reset,
  mul_unit_seq_if.slave bus
);

  localparam int unsigned P_W   = 2 * WIDTH;
  localparam int unsigned STEPS = WIDTH / RADIX_BITS;
  localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [P_W-1:0]   prod_q,   prod_d;
  logic [P_W-1:0]   mcand_q,  mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic             long_q,   long_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic             flag_n_q, flag_n_d;
  logic             flag_z_q, flag_z_d;

  logic             is_mla, is_long, is_lacc, is_signed;
  logic [P_W-1:0]   acc_init, sign_corr, step_sum;

  // Request decode; signed forms start from acc - 2^W*(a_msb*b + b_msb*a) so the unsigned loop yields the signed product.
  always_comb begin
    is_mla    = (bus.mode == 3'b001);
    is_long   = bus.mode[2];
    is_lacc   = (bus.mode == 3'b101) || (bus.mode == 3'b111);
    is_signed = (bus.mode[2:1] == 2'b11);
    acc_init  = '0;
    sign_corr = '0;
    if (is_mla)  acc_init = P_W'(bus.acc_lo);
    if (is_lacc) acc_init = {bus.acc_hi, bus.acc_lo};
    if (is_signed && bus.src_a[WIDTH-1]) sign_corr = sign_corr + {bus.src_b, {WIDTH{1'b0}}};
    if (is_signed && bus.src_b[WIDTH-1]) sign_corr = sign_corr + {bus.src_a, {WIDTH{1'b0}}};
    step_sum  = prod_q + mcand_q * P_W'(mplier_q[RADIX_BITS-1:0]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      long_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      flag_n_q <= 1'b0;
      flag_z_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      long_q   <= long_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      flag_n_q <= flag_n_d;
      flag_z_q <= flag_z_d;
    end
  end

  // Next state and registered outputs; flush overrides everything but leaves results untouched.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    long_d   = long_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    flag_n_d = flag_n_q;
    flag_z_d = flag_z_q;
    if (bus.flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          state_d = ST_IDLE;
          if (bus.start) begin
            state_d  = ST_CALC;
            cnt_d    = '0;
            prod_d   = acc_init - sign_corr;
            mcand_d  = P_W'(bus.src_a);
            mplier_d = bus.src_b;
            long_d   = is_long;
            busy_d   = 1'b1;
          end
        end
        ST_CALC: begin
          prod_d   = step_sum;
          mcand_d  = mcand_q << RADIX_BITS;
          mplier_d = mplier_q >> RADIX_BITS;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(STEPS - 1)) begin
            state_d  = ST_DONE;
            done_d   = 1'b1;
            res_lo_d = step_sum[WIDTH-1:0];
            if (long_q) begin
              res_hi_d = step_sum[P_W-1:WIDTH];
              flag_n_d = step_sum[P_W-1];
              flag_z_d = (step_sum == '0);
            end else begin
              res_hi_d = '0;
              flag_n_d = step_sum[WIDTH-1];
              flag_z_d = (step_sum[WIDTH-1:0] == '0);
            end
          end else begin
            busy_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result_lo = res_lo_q;
  assign bus.result_hi = res_hi_q;
  assign bus.flag_n    = flag_n_q;
  assign bus.flag_z    = flag_z_q;

endmodule

// File: tb/tb_mul_unit_seq.sv
// Bench for mul_unit_seq: radix-1 and radix-4 instances against a plain-arithmetic reference model.
module tb_mul_unit_seq;

  localparam int unsigned W = 32;

  typedef struct packed {
    logic         busy;
    logic         done;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         n;
    logic         z;
  } obs_t;

  typedef struct packed {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         n;
    logic         z;
  } res_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mul_unit_seq_if #(.WIDTH(W)) if1 ();
  mul_unit_seq_if #(.WIDTH(W)) if4 ();

  mul_unit_seq #(.WIDTH(W), .RADIX_BITS(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));
  mul_unit_seq #(.WIDTH(W), .RADIX_BITS(4)) dut4 (.clk(clk), .reset(reset), .bus(if4));

  task automatic drive(input bit r4, input logic st, input logic fl, input logic [2:0] md,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] lo, input logic [W-1:0] hi);
    if (r4) begin
      if4.start = st; if4.flush = fl; if4.mode = md;
      if4.src_a = a;  if4.src_b = b;  if4.acc_lo = lo; if4.acc_hi = hi;
    end else begin
      if1.start = st; if1.flush = fl; if1.mode = md;
      if1.src_a = a;  if1.src_b = b;  if1.acc_lo = lo; if1.acc_hi = hi;
    end
  endtask

  function automatic obs_t sample(input bit r4);
    obs_t o;
    if (r4) o = '{if4.busy, if4.done, if4.result_lo, if4.result_hi, if4.flag_n, if4.flag_z};
    else    o = '{if1.busy, if1.done, if1.result_lo, if1.result_hi, if1.flag_n, if1.flag_z};
    return o;
  endfunction

  // Reference: the architectural result of each mode using native 64-bit arithmetic.
  function automatic res_t model(input logic [2:0] md, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] lo, input logic [W-1:0] hi);
    logic [2*W-1:0] p;
    logic [2*W-1:0] acc64;
    longint         sa, sb;
    res_t           r;
    acc64 = {hi, lo};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (md)
      3'b001:  p = 64'(a) * 64'(b) + 64'(lo);
      3'b100:  p = 64'(a) * 64'(b);
      3'b101:  p = 64'(a) * 64'(b) + acc64;
      3'b110:  p = 64'(sa * sb);
      3'b111:  p = 64'(sa * sb) + acc64;
      default: p = 64'(a) * 64'(b);
    endcase
    r.lo = p[W-1:0];
    if (md[2]) begin
      r.hi = p[2*W-1:W];
      r.n  = p[2*W-1];
      r.z  = (p == '0);
    end else begin
      r.hi = '0;
      r.n  = p[W-1];
      r.z  = (p[W-1:0] == '0);
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  // Starts an op at the current falling edge and returns once done is seen (or the bound expires).
  task automatic run_op(input bit r4, input logic [2:0] md, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] lo, input logic [W-1:0] hi,
                        output int lat, output int bcnt, output bit held, output obs_t fin);
    obs_t o, prev;
    prev = sample(r4);
    drive(r4, 1'b1, 1'b0, md, a, b, lo, hi);
    @(negedge clk);
    drive(r4, 1'b0, 1'b0, 3'($urandom), $urandom, $urandom, $urandom, $urandom);
    lat  = -1;
    bcnt = 0;
    held = 1'b1;
    o    = sample(r4);
    for (int s = 0; s < 300; s++) begin
      o = sample(r4);
      if (o.done) begin
        lat = s;
        break;
      end
      if (o.busy) bcnt++;
      if ({o.lo, o.hi, o.n, o.z} !== {prev.lo, prev.hi, prev.n, prev.z}) held = 1'b0;
      @(negedge clk);
    end
    fin = o;
  endtask

  task automatic test_reset();
    obs_t o;
    for (int r = 0; r < 2; r++) begin
      o = sample(r[0]);
      checks++;
      if (o.busy !== 1'b0 || o.done !== 1'b0) begin
        errors++; $display("FAIL reset_hs dut%0d got busy=%b done=%b want 0 0", r, o.busy, o.done);
      end
      checks++;
      if ({o.lo, o.hi, o.n, o.z} !== '0) begin
        errors++; $display("FAIL reset_res dut%0d got lo=%h hi=%h n=%b z=%b want all 0", r, o.lo, o.hi, o.n, o.z);
      end
    end
  endtask

  task automatic test_mul_basic();
    int lat, bcnt; bit held; obs_t o;
    run_op(1'b0, 3'b000, 32'd7, 32'd6, 32'd0, 32'd0, lat, bcnt, held, o);
    checks++; if (lat !== 32) begin errors++; $display("FAIL mul_latency got %0d want 32", lat); end
    checks++; if (bcnt !== 32) begin errors++; $display("FAIL mul_busy_cycles got %0d want 32", bcnt); end
    checks++; if (!held) begin errors++; $display("FAIL mul_hold_during_calc got changed want held"); end
    checks++;
    if ({o.lo, o.hi, o.n, o.z} !== {32'd42, 32'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL mul_result got lo=%h hi=%h n=%b z=%b want 2a 0 0 0", o.lo, o.hi, o.n, o.z);
    end
    @(negedge clk);
    o = sample(1'b0);
    checks++;
    if (o.done !== 1'b0 || o.busy !== 1'b0 || o.lo !== 32'd42) begin
      errors++; $display("FAIL mul_after_done got done=%b busy=%b lo=%h want 0 0 2a", o.done, o.busy, o.lo);
    end
  endtask

  task automatic test_long_directed();
    logic [2:0]   md [4] = '{3'b110, 3'b101, 3'b001, 3'b000};
    logic [W-1:0] a  [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0};
    logic [W-1:0] b  [4] = '{32'd5, 32'hFFFF_FFFF, 32'd2, 32'h1234};
    logic [W-1:0] al [4] = '{32'h0, 32'h1, 32'h5, 32'h0};
    logic [W-1:0] el [4] = '{32'hFFFF_FFF1, 32'h0000_0002, 32'h5, 32'h0};
    logic [W-1:0] eh [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0, 32'h0};
    logic [1:0]   ef [4] = '{2'b10, 2'b10, 2'b00, 2'b01};
    int lat, bcnt; bit held; obs_t o;
    for (int i = 0; i < 4; i++) begin
      run_op(1'b0, md[i], a[i], b[i], al[i], 32'h0, lat, bcnt, held, o);
      checks++;
      if (lat !== 32 || {o.lo, o.hi, o.n, o.z} !== {el[i], eh[i], ef[i]}) begin
        errors++;
        $display("FAIL directed_%0d got lat=%0d lo=%h hi=%h nz=%b%b want lat=32 lo=%h hi=%h nz=%b",
                 i, lat, o.lo, o.hi, o.n, o.z, el[i], eh[i], ef[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_busy_start();
    int lat = -1; obs_t o;
    drive(1'b0, 1'b1, 1'b0, 3'b000, 32'd3, 32'd4, 32'd0, 32'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'd3, 32'd4, 32'd0, 32'd0);
    o = sample(1'b0);
    for (int s = 0; s < 300; s++) begin
      o = sample(1'b0);
      if (o.done) begin lat = s; break; end
      if (s == 10) drive(1'b0, 1'b1, 1'b0, 3'b001, 32'd100, 32'd100, 32'd7, 32'd0);
      if (s == 11) drive(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0);
      @(negedge clk);
    end
    checks++; if (lat !== 32) begin errors++; $display("FAIL busy_start_latency got %0d want 32", lat); end
    checks++; if (o.lo !== 32'd12) begin errors++; $display("FAIL busy_start_result got %h want c", o.lo); end
    @(negedge clk);
    o = sample(1'b0);
    checks++;
    if (o.busy !== 1'b0) begin errors++; $display("FAIL busy_start_restart got busy=%b want 0", o.busy); end
  endtask

  task automatic test_flush();
    int lat, bcnt, dones = 0, busy_late = 0; bit held; obs_t o;
    run_op(1'b0, 3'b000, 32'd5, 32'd5, 32'd0, 32'd0, lat, bcnt, held, o);
    checks++; if (o.lo !== 32'd25) begin errors++; $display("FAIL flush_setup got %h want 19", o.lo); end
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 3'b000, 32'd9, 32'd9, 32'd0, 32'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0);
    for (int s = 0; s < 60; s++) begin
      o = sample(1'b0);
      if (o.done) dones++;
      if (s >= 11 && o.busy) busy_late++;
      if (s == 10) drive(1'b0, 1'b1, 1'b1, 3'b000, 32'd2, 32'd2, 32'd0, 32'd0);
      if (s == 11) drive(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0);
      @(negedge clk);
    end
    o = sample(1'b0);
    checks++; if (dones !== 0) begin errors++; $display("FAIL flush_no_done got %0d pulses want 0", dones); end
    checks++; if (busy_late !== 0) begin errors++; $display("FAIL flush_idle got %0d busy cycles want 0", busy_late); end
    checks++; if (o.lo !== 32'd25) begin errors++; $display("FAIL flush_hold got %h want 19", o.lo); end
  endtask

  task automatic test_back_to_back();
    int lat, bcnt; bit held; obs_t o; res_t e;
    logic [W-1:0] a, b;
    run_op(1'b1, 3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, lat, bcnt, held, o);
    checks++; if (lat !== 8) begin errors++; $display("FAIL r4_latency got %0d want 8", lat); end
    checks++;
    if ({o.lo, o.hi, o.n, o.z} !== {32'h0, 32'h1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL r4_smlal got lo=%h hi=%h n=%b z=%b want 0 1 0 0", o.lo, o.hi, o.n, o.z);
    end
    a = $urandom; b = $urandom;
    e = model(3'b100, a, b, 32'h0, 32'h0);
    run_op(1'b1, 3'b100, a, b, 32'h0, 32'h0, lat, bcnt, held, o);
    checks++;
    if (lat !== 8 || bcnt !== 8) begin
      errors++; $display("FAIL b2b_timing got lat=%0d busy=%0d want 8 8", lat, bcnt);
    end
    checks++; if (!held) begin errors++; $display("FAIL b2b_hold got changed want held"); end
    checks++;
    if ({o.lo, o.hi, o.n, o.z} !== e) begin
      errors++; $display("FAIL b2b_result got %h_%h want %h_%h", o.hi, o.lo, e.hi, e.lo);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    int lat, bcnt; bit held; obs_t o; res_t e;
    logic [2:0] md; logic [W-1:0] a, b, lo, hi;
    for (int i = 0; i < 24; i++) begin
      md = 3'($urandom);
      a = rnd_op(); b = rnd_op(); lo = rnd_op(); hi = rnd_op();
      e = model(md, a, b, lo, hi);
      run_op(i[0], md, a, b, lo, hi, lat, bcnt, held, o);
      checks++;
      if (lat !== (i[0] ? 8 : 32) || {o.lo, o.hi, o.n, o.z} !== e) begin
        errors++;
        $display("FAIL random_%0d mode=%b a=%h b=%h acc=%h_%h got lat=%0d %h_%h nz=%b%b want %h_%h nz=%b%b",
                 i, md, a, b, hi, lo, lat, o.hi, o.lo, o.n, o.z, e.hi, e.lo, e.n, e.z);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    drive(1'b0, 1'b1, 1'b0, 3'b000, 32'd7, 32'd7, 32'd0, 32'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0);
    repeat (5) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    for (int r = 0; r < 2; r++) begin
      o = sample(r[0]);
      checks++;
      if (o !== '0) begin
        errors++; $display("FAIL reset_mid dut%0d got busy=%b done=%b lo=%h hi=%h n=%b z=%b want all 0",
                           r, o.busy, o.done, o.lo, o.hi, o.n, o.z);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    o = sample(1'b0);
    checks++;
    if (o.busy !== 1'b0 || o.done !== 1'b0) begin
      errors++; $display("FAIL reset_mid_idle got busy=%b done=%b want 0 0", o.busy, o.done);
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_mul_basic();
    test_long_directed();
    test_busy_start();
    test_flush();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
